pulse_generator: RTL and testbench
==================================

// Module: pulse_generator
// PURPOSE
//  Generates a periodic rectangular pulse with programmable period and high time, both in clock cycles.
//  It is the source-side counterpart of the duration meter: a meter on d_out reports q = PERIOD and duty_cycle = HIGH.
//  It drives synchronization outputs and provides the loopback stimulus for meter self-test.
// PARAMETERS
//  W          32   width of period/high-time/burst registers and counters
// PORTS
//  clock         in   1   system clock; all logic on posedge
//  reset         in   1   synchronous, active-low reset
//  enable        in   1   level; 1 = run, 0 = stop at end of current period
//  period_in     in   W   requested period P in cycles
//  high_in       in   W   requested high time H in cycles
//  load          in   1   1-cycle strobe: capture period_in/high_in into pending shadow
//  load_ack      out  1   1-cycle pulse, the cycle after load is sampled
//  burst_len     in   W   pulses per run, 0 = continuous (PULSE_GEN_BURST_EN only)
//  d_out         out  1   generated pulse, registered
//  period_start  out  1   1-cycle strobe, high in the cycle d_out first goes high
//  busy          out  1   1 while in HIGH or LOW state
//  cfg_err       out  1   sticky; set when an active config has P < 2; cleared by load of valid config
//  done          out  1   1-cycle pulse after last burst pulse (PULSE_GEN_BURST_EN only)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, cnt=0, active/pending P=0,H=0, all outputs 0.
//  - Config: load captures inputs into pending; pending copied to active when in IDLE or at period wrap.
//    load in the wrap cycle itself: takes effect at the following wrap. Back-to-back loads: last wins.
//  - Clip: Hc = min(H, P-1), so every non-zero pulse has a falling edge. H=0: d_out low whole period.
//  - States: IDLE -> HIGH (enable & P>=2 & Hc>0) or LOW (enable & P>=2 & Hc==0);
//    HIGH -> LOW when cnt==Hc-1; LOW -> HIGH/LOW at wrap (cnt==P-1) if enable, else IDLE.
//  - Latency: enable sampled high in IDLE -> d_out=1 and period_start=1 on the next cycle (cnt=0).
//  - cnt: 0..P-1, increments each busy cycle, wraps to 0; d_out = (state==HIGH).
//  - Rising edges exactly P cycles apart; high phase exactly Hc cycles.
//  - enable dropped mid-period: current period completes in full, then IDLE, d_out=0. No truncated pulse.
//  - P<2 at start or wrap: stay/go IDLE, set cfg_err, d_out=0.
//  - Reset mid-operation: next posedge returns everything to reset values; pending config discarded.
//  - Counter arithmetic is W-bit unsigned; P up to 2^W-1 with no overflow (cnt never exceeds P-1).
// CONFIGURATION
//  PULSE_GEN_BURST_EN defined: burst_len and done exist. Nonzero burst_len (sampled at IDLE exit)
//    counts pulses; after the Nth period ends -> IDLE, done=1 for one cycle, d_out=0 until enable
//    is deasserted and reasserted. burst_len=0 behaves as continuous.
//  Not defined: ports burst_len/done absent; generation is always continuous while enable=1.
// TESTING
//  - load P=10,H=3, enable=1 -> d_out 3 high/7 low repeating, period_start every 10 cycles; meter loopback q=10, duty_cycle=3.
//  - P=10,H=0 -> d_out stays 0, busy=1; P=10,H=12 -> high 9 cycles, low 1.
//  - P=1, enable=1 -> cfg_err=1, busy=0, d_out=0; then load P=4,H=2 -> cfg_err=0, pulses 2/2.
//  - running P=10,H=3, load P=6,H=1 at cnt=4 -> current period stays 10/3, next periods 6/1; load_ack 1 cycle after load.
//  - enable dropped at cnt=1 of P=8,H=4 -> period completes (8 cycles total), then IDLE; reset=0 mid-HIGH -> d_out=0, busy=0 next cycle.
//  - PULSE_GEN_BURST_EN, burst_len=4, P=5,H=2 -> exactly 4 pulses, done pulse at cycle 21 after start, no 5th pulse.

Source files
------------

// File: rtl/pulse_generator.sv
// pulse_generator: periodic rectangular pulse with programmable period P and high time H (cycles).
// Optional burst mode (burst_len, done) is compiled in when PULSE_GEN_BURST_EN is defined.
module pulse_generator #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] period_in,
  input  logic [W-1:0] high_in,
  input  logic         load,
  output logic         load_ack,
`ifdef PULSE_GEN_BURST_EN
  input  logic [W-1:0] burst_len,
  output logic         done,
`endif
  output logic         d_out,
  output logic         period_start,
  output logic         busy,
  output logic         cfg_err
);

  // state | meaning
  // IDLE  | stopped; active config follows pending every cycle
  // HIGH  | d_out high, cnt in [0, Hc-1]
  // LOW   | d_out low, cnt in [Hc, P-1]; the period wraps from here
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [W-1:0] one_w = W'(1);
  localparam logic [W-1:0] two_w = W'(2);

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] act_p, act_h, pend_p, pend_h;
  logic [W-1:0] act_hc, pend_hc;
  logic         copy_cfg, set_err, wrap, finish, hold;

  // Hc = min(H, P-1) guarantees a falling edge inside every period.
  function automatic logic [W-1:0] clip_high(input logic [W-1:0] h, input logic [W-1:0] p);
    logic [W-1:0] r;
    r = h;
    if (p == '0) r = '0;
    else if (h > p - one_w) r = p - one_w;
    return r;
  endfunction

  assign act_hc  = clip_high(act_h, act_p);
  assign pend_hc = clip_high(pend_h, pend_p);
  assign wrap    = (state == LOW) && (cnt == act_p - one_w);

`ifdef PULSE_GEN_BURST_EN
  logic [W-1:0] burst_rem;
  logic         hold_q;

  assign hold   = hold_q;
  assign finish = wrap && (burst_rem == one_w);
`else
  assign hold   = 1'b0;
  assign finish = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    copy_cfg  = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        copy_cfg = 1'b1;
        cnt_nxt  = '0;
        if (enable && !hold) begin
          if (pend_p < two_w) set_err = 1'b1;
          else state_nxt = (pend_hc != '0) ? HIGH : LOW;
        end
      end
      HIGH: begin
        cnt_nxt = cnt + one_w;
        if (cnt == act_hc - one_w) state_nxt = LOW;
      end
      LOW: begin
        if (wrap) begin
          // Pending config becomes active only on a period boundary.
          copy_cfg = 1'b1;
          cnt_nxt  = '0;
          if (finish || !enable) begin
            state_nxt = IDLE;
          end else if (pend_p < two_w) begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = (pend_hc != '0) ? HIGH : LOW;
          end
        end else begin
          cnt_nxt = cnt + one_w;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      act_p        <= '0;
      act_h        <= '0;
      pend_p       <= '0;
      pend_h       <= '0;
      load_ack     <= 1'b0;
      d_out        <= 1'b0;
      period_start <= 1'b0;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (copy_cfg) begin
        act_p <= pend_p;
        act_h <= pend_h;
      end
      if (load) begin
        pend_p <= period_in;
        pend_h <= high_in;
      end
      load_ack     <= load;
      d_out        <= (state_nxt == HIGH);
      period_start <= (state_nxt == HIGH) && (state != HIGH);
      busy         <= (state_nxt != IDLE);
      // A valid load clears the error even if the old config trips it this cycle.
      if (load && (period_in >= two_w)) cfg_err <= 1'b0;
      else if (set_err) cfg_err <= 1'b1;
    end
  end

`ifdef PULSE_GEN_BURST_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      burst_rem <= '0;
      hold_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if ((state == IDLE) && (state_nxt != IDLE)) burst_rem <= burst_len;
      else if (wrap && (burst_rem != '0)) burst_rem <= burst_rem - one_w;
      // After a finished burst, enable must be seen low before another run.
      if (finish) hold_q <= 1'b1;
      else if (!enable) hold_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator: scenario tasks plus a randomized run,
// each compared cycle by cycle against a period/position reference model.
`timescale 1ns/1ps
module tb_pulse_generator;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, enable, load;
  logic [W-1:0] period_in, high_in, burst_len;
  logic         load_ack, d_out, period_start, busy, cfg_err, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  pulse_generator #(.W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .period_in    (period_in),
    .high_in      (high_in),
    .load         (load),
    .load_ack     (load_ack),
`ifdef PULSE_GEN_BURST_EN
    .burst_len    (burst_len),
    .done         (done),
`endif
    .d_out        (d_out),
    .period_start (period_start),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

`ifndef PULSE_GEN_BURST_EN
  assign done = 1'b0;
`endif

  // Reference model: a running period described by its position and captured P/H.
  bit           m_run, m_err, m_ack, m_done, m_hold;
  logic [W-1:0] m_pos, m_p, m_h, m_pp, m_ph, m_rem;

  function automatic logic [W-1:0] hclip(input logic [W-1:0] p, input logic [W-1:0] h);
    return (h > p - 1) ? p - 1 : h;
  endfunction

  function automatic logic [5:0] expected();
    logic ed;
    ed = m_run && (m_pos < hclip(m_p, m_h));
    return {ed, ed && (m_pos == 0), m_run, m_err, m_ack, m_done};
  endfunction

  function automatic logic [5:0] obs();
    return {d_out, period_start, busy, cfg_err, load_ack, done};
  endfunction

  task automatic model_step();
    bit fin, go, err_set;
    fin = 0; go = 0; err_set = 0;
    if (!reset) begin
      m_run = 0; m_pos = 0; m_p = 0; m_h = 0; m_pp = 0; m_ph = 0;
      m_err = 0; m_ack = 0; m_done = 0; m_hold = 0; m_rem = 0;
    end else begin
      if (m_run && (m_pos != m_p - 1)) begin
        m_pos = m_pos + 1;
      end else begin
        fin = m_run && (m_rem == 1);
        go = !fin && enable && !m_hold && (m_pp >= 2);
        err_set = !fin && enable && !m_hold && (m_pp < 2);
        if (go) begin
          if (!m_run) m_rem = burst_len;
          else if (m_rem != 0) m_rem = m_rem - 1;
          m_p = m_pp; m_h = m_ph; m_pos = 0;
        end
        m_run = go;
      end
      if (fin) m_hold = 1;
      else if (!enable) m_hold = 0;
      if (load && (period_in >= 2)) m_err = 0;
      else if (err_set) m_err = 1;
      if (load) begin m_pp = period_in; m_ph = high_in; end
      m_ack = load;
      m_done = fin;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic do_load(input logic [W-1:0] p, input logic [W-1:0] h);
    load = 1; period_in = p; high_in = h;
    step();
    load = 0;
  endtask

  task automatic go_idle(output bit ok);
    enable = 0; load = 0; ok = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 0; enable = 0; load = 0; period_in = 0; high_in = 0; burst_len = 0;
    repeat (3) step();
    checks++;
    if (obs() !== 6'b0) begin errors++; $display("FAIL reset_outputs dut=%b exp=000000", obs()); end
    reset = 1;
    step();
    checks++;
    if (obs() !== expected()) begin errors++; $display("FAIL reset_release dut=%b model=%b", obs(), expected()); end
  endtask

  task automatic test_basic();
    int rises, highs, first;
    bit ok;
    do_load(10, 3);
    checks++;
    if (load_ack !== 1'b1) begin errors++; $display("FAIL basic_load_ack got=%b exp=1", load_ack); end
    enable = 1; rises = 0; highs = 0; first = -1;
    for (int i = 0; i < 45; i++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL basic cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      if (period_start && first < 0) first = i;
      if (first >= 0 && i < first + 30) begin rises += int'(period_start); highs += int'(d_out); end
    end
    checks++;
    if (first != 0) begin errors++; $display("FAIL basic_latency first_rise=%0d exp=0", first); end
    checks++;
    if (rises != 3 || highs != 9) begin errors++; $display("FAIL basic_shape rises=%0d highs=%0d exp=3,9", rises, highs); end
    go_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_stop busy=%b exp=0", busy); end
  endtask

  task automatic test_zero_high();
    int highs, busys, starts;
    bit ok;
    do_load(10, 0);
    enable = 1; highs = 0; busys = 0; starts = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL zero_high cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      highs += int'(d_out); busys += int'(busy); starts += int'(period_start);
    end
    checks++;
    if (highs != 0 || busys != 25) begin errors++; $display("FAIL zero_high_shape highs=%0d busy=%0d exp=0,25", highs, busys); end
    go_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_high_stop busy=%b exp=0", busy); end
  endtask

  task automatic test_clip();
    int highs, first;
    bit ok;
    do_load(10, 12);
    enable = 1; highs = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL clip cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      if (period_start && first < 0) first = i;
      if (first >= 0 && i < first + 20) highs += int'(d_out);
    end
    checks++;
    if (highs != 18) begin errors++; $display("FAIL clip_highs got=%0d exp=18", highs); end
    go_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clip_stop busy=%b exp=0", busy); end
  endtask

  task automatic test_cfg_err();
    int highs, rises, first;
    bit ok;
    do_load(1, 0);
    enable = 1;
    repeat (4) step();
    checks++;
    if ({cfg_err, busy, d_out} !== 3'b100) begin errors++; $display("FAIL cfg_err_set err_busy_dout=%b exp=100", {cfg_err, busy, d_out}); end
    do_load(4, 2);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); end
    highs = 0; rises = 0; first = -1;
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL cfg_err cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      if (period_start && first < 0) first = i;
      if (first >= 0 && i < first + 8) begin highs += int'(d_out); rises += int'(period_start); end
    end
    checks++;
    if (highs != 4 || rises != 2) begin errors++; $display("FAIL cfg_err_pulses highs=%0d rises=%0d exp=4,2", highs, rises); end
    go_idle(ok);
  endtask

  task automatic test_reload();
    int rs[$];
    int hi[8];
    bit ok;
    foreach (hi[k]) hi[k] = 0;
    do_load(10, 3);
    enable = 1;
    for (int i = 0; i < 35; i++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL reload cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      if (i == 5) begin
        checks++;
        if (load_ack !== 1'b1) begin errors++; $display("FAIL reload_ack got=%b exp=1", load_ack); end
        load = 0;
      end
      if (i == 4) begin load = 1; period_in = 6; high_in = 1; end
      if (period_start) rs.push_back(cyc);
      if (rs.size() > 0 && rs.size() <= 8) hi[rs.size() - 1] += int'(d_out);
    end
    checks++;
    if (rs.size() < 4) begin
      errors++; $display("FAIL reload_rises got=%0d exp>=4", rs.size());
    end else if (rs[1] - rs[0] != 10 || rs[2] - rs[1] != 6 || rs[3] - rs[2] != 6) begin
      errors++; $display("FAIL reload_periods got=%0d,%0d,%0d exp=10,6,6", rs[1] - rs[0], rs[2] - rs[1], rs[3] - rs[2]);
    end
    checks++;
    if (hi[0] != 3 || hi[1] != 1 || hi[2] != 1) begin errors++; $display("FAIL reload_highs got=%0d,%0d,%0d exp=3,1,1", hi[0], hi[1], hi[2]); end
    go_idle(ok);
  endtask

  task automatic test_enable_drop();
    int busys, highs;
    do_load(8, 4);
    enable = 1;
    busys = 0; highs = 0;
    repeat (2) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL enable_drop cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      busys += int'(busy); highs += int'(d_out);
    end
    enable = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL enable_drop cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      if (!busy) break;
      busys += int'(busy); highs += int'(d_out);
    end
    checks++;
    if (busys != 8 || highs != 4 || d_out !== 1'b0) begin
      errors++; $display("FAIL enable_drop_period busy_cycles=%0d highs=%0d d_out=%b exp=8,4,0", busys, highs, d_out);
    end
  endtask

  task automatic test_back_to_back();
    int rs[$];
    int highs;
    bit ok;
    do_load(5, 1);
    do_load(7, 2);
    enable = 1; highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL back_to_back cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      if (period_start) rs.push_back(cyc);
      if (rs.size() == 1) highs += int'(d_out);
    end
    checks++;
    if (rs.size() < 2 || rs[1] - rs[0] != 7 || highs != 2) begin
      errors++; $display("FAIL back_to_back_cfg rises=%0d highs=%0d exp_period=7 exp_high=2", rs.size(), highs);
    end
    go_idle(ok);
  endtask

  task automatic test_reset_mid();
    do_load(8, 4);
    enable = 1;
    repeat (2) step();
    reset = 0;
    step();
    checks++;
    if (obs() !== 6'b0) begin errors++; $display("FAIL reset_mid dut=%b exp=000000", obs()); end
    reset = 1;
    repeat (3) begin
      step();
      checks++;
      if (busy !== 1'b0 || obs() !== expected()) begin errors++; $display("FAIL reset_mid_discard dut=%b model=%b", obs(), expected()); end
    end
    enable = 0;
    step();
  endtask

`ifdef PULSE_GEN_BURST_EN
  task automatic test_burst();
    int rises, ndone, dcyc;
    bit ok;
    do_load(5, 2);
    burst_len = 4;
    enable = 1; rises = 0; ndone = 0; dcyc = -1;
    for (int k = 1; k <= 45; k++) begin
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL burst cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
      rises += int'(period_start);
      if (done) begin ndone++; dcyc = k; end
    end
    checks++;
    if (rises != 4 || ndone != 1 || dcyc != 21) begin
      errors++; $display("FAIL burst_shape rises=%0d done_pulses=%0d done_cycle=%0d exp=4,1,21", rises, ndone, dcyc);
    end
    enable = 0;
    step();
    enable = 1;
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL burst_rearm busy=%b exp=1", busy); end
    burst_len = 0;
    go_idle(ok);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) >= 2);
      if ($urandom_range(0, 99) < 6) enable = ~enable;
      load = ($urandom_range(0, 99) < 12);
      period_in = $urandom_range(0, 14);
      high_in = $urandom_range(0, 16);
`ifdef PULSE_GEN_BURST_EN
      burst_len = $urandom_range(0, 3);
`endif
      step();
      checks++;
      if (obs() !== expected()) begin errors++; $display("FAIL random cyc=%0d dut=%b model=%b", cyc, obs(), expected()); end
    end
    reset = 1; load = 0; enable = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_high();
    test_clip();
    test_cfg_err();
    test_reload();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
`ifdef PULSE_GEN_BURST_EN
    test_burst();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
